vga_scan_generator: RTL and testbench

Raster timing source for the 640x480 @ 60 Hz VGA output path. Divides the 50 MHz system clock into a 25 MHz pixel enable and runs horizontal and vertical scan counters. Drives DrawX/DrawY to the color mapper and sprite/word logic, and drives sync/blank/pixel-clock to the DAC. Sync and blank outputs are delayed by a programmable number of pixels, so they line up with the color mapper's registered frame-RAM output.

---
 rtl/vga_scan_generator.sv | 135 +++++++++++++
 tb/tb_vga_scan_generator.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_generator.sv
// vga_scan_generator: 640x480@60 raster timing from a 50 MHz clock.
// A toggling pixel enable divides Clk by two and advances the h/v scan counters.
// Sync and blank are derived from the counters, then delayed to line up with
// the colour mapper's registered pixel data.
//
// Ports:
//   Clk, Reset_n   - system clock, async active-low reset
//   VGA_CLK        - 25 MHz pixel clock to the DAC
//   VGA_HS, VGA_VS - active-low syncs, delayed PIPE_DELAY pixels
//   VGA_BLANK_N    - high while the delayed pixel is visible
//   VGA_SYNC_N     - tied low
//   DrawX, DrawY   - undelayed scan position
//   frame_start    - one-Clk pulse at frame wrap
//   frame_count    - frames completed since reset (wraps)
module vga_scan_generator #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DEPTH   = PIPE_DELAY + 1;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic             pix_en;
    logic             vga_clk_q;
    logic [9:0]       h_count;
    logic [9:0]       v_count;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             h_wrap;
    logic             v_wrap;
    logic             frame_wrap;
    logic             hs_raw;
    logic             vs_raw;
    logic             blank_raw_n;
    logic [15:0]      fc_q;
    logic [DEPTH-1:0] hs_pipe;
    logic [DEPTH-1:0] vs_pipe;
    logic [DEPTH-1:0] blank_pipe;

    always_comb begin
        h_wrap     = (h_count == H_LAST);
        v_wrap     = (v_count == V_LAST);
        frame_wrap = pix_en && h_wrap && v_wrap;
        h_next     = h_count;
        v_next     = v_count;
        if (pix_en) begin
            if (h_wrap) begin
                h_next = '0;
                v_next = v_wrap ? '0 : v_count + 10'd1;
            end else begin
                h_next = h_count + 10'd1;
            end
        end
        // Raw terms use the count being loaded this edge, so stage 0
        // carries no extra pixel of delay relative to DrawX/DrawY.
        hs_raw      = !((h_next >= HS_LO) && (h_next < HS_HI));
        vs_raw      = !((v_next >= VS_LO) && (v_next < VS_HI));
        blank_raw_n = (h_next < H_VIS) && (v_next < V_VIS);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_en      <= 1'b0;
            vga_clk_q   <= 1'b1;
            h_count     <= '0;
            v_count     <= '0;
            frame_start <= 1'b0;
            fc_q        <= '0;
            hs_pipe     <= '1;
            vs_pipe     <= '1;
            blank_pipe  <= '0;
        end else begin
            pix_en      <= ~pix_en;
            // Holds the complement of the new pix_en value.
            vga_clk_q   <= pix_en;
            h_count     <= h_next;
            v_count     <= v_next;
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                fc_q <= fc_q + 16'd1;
            end
            // Stage 0 reloads every Clk (stable between pixel enables);
            // later stages advance one pixel at a time.
            hs_pipe[0]    <= hs_raw;
            vs_pipe[0]    <= vs_raw;
            blank_pipe[0] <= blank_raw_n;
            if (pix_en) begin
                for (int k = 1; k < DEPTH; k++) begin
                    hs_pipe[k]    <= hs_pipe[k-1];
                    vs_pipe[k]    <= vs_pipe[k-1];
                    blank_pipe[k] <= blank_pipe[k-1];
                end
            end
        end
    end

    assign VGA_CLK     = vga_clk_q;
    assign VGA_HS      = hs_pipe[DEPTH-1];
    assign VGA_VS      = vs_pipe[DEPTH-1];
    assign VGA_BLANK_N = blank_pipe[DEPTH-1];
    assign VGA_SYNC_N  = 1'b0;
    assign DrawX       = h_count;
    assign DrawY       = v_count;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator: one default-timing instance plus four
// reduced-timing instances (PIPE_DELAY 0..3) checked against a raster model.
module tb_vga_scan_generator;

    typedef struct packed {
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        sn;
        logic        fs;
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic [15:0] fc;
    } obs_t;

    localparam int N = 5;

    // index 0: default timing, PIPE_DELAY 1; 1..4: 25x11 raster, PIPE_DELAY 0..3
    int p_hv [N] = '{640, 16, 16, 16, 16};
    int p_hf [N] = '{16, 2, 2, 2, 2};
    int p_hs [N] = '{96, 4, 4, 4, 4};
    int p_hb [N] = '{48, 3, 3, 3, 3};
    int p_vv [N] = '{480, 6, 6, 6, 6};
    int p_vf [N] = '{10, 1, 1, 1, 1};
    int p_vs [N] = '{2, 2, 2, 2, 2};
    int p_vb [N] = '{33, 2, 2, 2, 2};
    int p_pd [N] = '{1, 0, 1, 2, 3};
    int fc_off [N] = '{0, 0, 0, 0, 0};

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        vclk [N];
    logic        hs   [N];
    logic        vs   [N];
    logic        bn   [N];
    logic        sn   [N];
    logic        fs   [N];
    logic [9:0]  dx   [N];
    logic [9:0]  dy   [N];
    logic [15:0] fc   [N];

    int n_checks = 0;
    int n_errors = 0;
    int t = 0;
    bit cmp_en = 1'b0;
    bit mon_en = 1'b0;

    always #5 Clk = ~Clk;

    vga_scan_generator u_def (
        .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(vclk[0]), .VGA_HS(hs[0]),
        .VGA_VS(vs[0]), .VGA_BLANK_N(bn[0]), .VGA_SYNC_N(sn[0]),
        .DrawX(dx[0]), .DrawY(dy[0]), .frame_start(fs[0]),
        .frame_count(fc[0])
    );

    vga_scan_generator #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .PIPE_DELAY(0)
    ) u_s0 (
        .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(vclk[1]), .VGA_HS(hs[1]),
        .VGA_VS(vs[1]), .VGA_BLANK_N(bn[1]), .VGA_SYNC_N(sn[1]),
        .DrawX(dx[1]), .DrawY(dy[1]), .frame_start(fs[1]),
        .frame_count(fc[1])
    );

    vga_scan_generator #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .PIPE_DELAY(1)
    ) u_s1 (
        .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(vclk[2]), .VGA_HS(hs[2]),
        .VGA_VS(vs[2]), .VGA_BLANK_N(bn[2]), .VGA_SYNC_N(sn[2]),
        .DrawX(dx[2]), .DrawY(dy[2]), .frame_start(fs[2]),
        .frame_count(fc[2])
    );

    vga_scan_generator #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .PIPE_DELAY(2)
    ) u_s2 (
        .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(vclk[3]), .VGA_HS(hs[3]),
        .VGA_VS(vs[3]), .VGA_BLANK_N(bn[3]), .VGA_SYNC_N(sn[3]),
        .DrawX(dx[3]), .DrawY(dy[3]), .frame_start(fs[3]),
        .frame_count(fc[3])
    );

    vga_scan_generator #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .PIPE_DELAY(3)
    ) u_s3 (
        .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(vclk[4]), .VGA_HS(hs[4]),
        .VGA_VS(vs[4]), .VGA_BLANK_N(bn[4]), .VGA_SYNC_N(sn[4]),
        .DrawX(dx[4]), .DrawY(dy[4]), .frame_start(fs[4]),
        .frame_count(fc[4])
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Clk edges since reset release.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) t <= 0;
        else          t <= t + 1;
    end

    // Raster model: after tt edges the scan has advanced tt/2 pixels;
    // sync/blank describe the pixel PIPE_DELAY positions earlier.
    function automatic obs_t model(input int i, input int tt, input logic rn);
        obs_t e;
        int ht, vt, ft, n, m, mh, mv;
        e      = '0;
        e.vclk = 1'b1;
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        if (!rn) return e;
        ht = p_hv[i] + p_hf[i] + p_hs[i] + p_hb[i];
        vt = p_vv[i] + p_vf[i] + p_vs[i] + p_vb[i];
        ft = ht * vt;
        n  = tt / 2;
        e.vclk = (tt % 2 == 0) ? 1'b1 : 1'b0;
        e.dx   = 10'(n % ht);
        e.dy   = 10'((n / ht) % vt);
        e.fs   = (tt > 0 && tt % 2 == 0 && n % ft == 0) ? 1'b1 : 1'b0;
        e.fc   = 16'(n / ft + fc_off[i]);
        if (tt > 0 && n >= p_pd[i]) begin
            m  = n - p_pd[i];
            mh = m % ht;
            mv = (m / ht) % vt;
            e.hs = (mh >= p_hv[i] + p_hf[i] &&
                    mh < p_hv[i] + p_hf[i] + p_hs[i]) ? 1'b0 : 1'b1;
            e.vs = (mv >= p_vv[i] + p_vf[i] &&
                    mv < p_vv[i] + p_vf[i] + p_vs[i]) ? 1'b0 : 1'b1;
            e.bn = (mh < p_hv[i] && mv < p_vv[i]) ? 1'b1 : 1'b0;
        end
        return e;
    endfunction

    always @(negedge Clk) begin
        if (cmp_en) begin
            for (int i = 0; i < N; i++) begin
                obs_t e;
                obs_t a;
                e = model(i, t, Reset_n);
                a = '{vclk[i], hs[i], vs[i], bn[i], sn[i], fs[i],
                      dx[i], dy[i], fc[i]};
                chk($sformatf("model i%0d t%0d", i, t), 64'(a), 64'(e));
            end
        end
    end

    // Edge/interval recorders for the directed timing checks.
    int  hs_fall_t = -1, hs_rise_t = -1, bn_rise_t = -1, bn_fall_t = -1;
    int  fs_t [$];
    int  fc_at [$];
    int  fs_run = 0, fs_run_max = 0, vs_lo_n = 0;
    int  t_dx [N] = '{-1, -1, -1, -1, -1};
    int  t_bf [N] = '{-1, -1, -1, -1, -1};
    logic prev_hs0 = 1'b1, prev_bn0 = 1'b0;
    logic prev_bn [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    always @(negedge Clk) begin
        if (mon_en) begin
            if (prev_hs0 && !hs[0] && hs_fall_t < 0) hs_fall_t = t;
            if (!prev_hs0 && hs[0] && hs_fall_t >= 0 && hs_rise_t < 0)
                hs_rise_t = t;
            if (!prev_bn0 && bn[0] && t > 1600 && bn_rise_t < 0)
                bn_rise_t = t;
            if (prev_bn0 && !bn[0] && bn_rise_t >= 0 && bn_fall_t < 0)
                bn_fall_t = t;
            prev_hs0 = hs[0];
            prev_bn0 = bn[0];
            if (fs[1]) begin
                fs_t.push_back(t);
                fc_at.push_back(int'(fc[1]));
                fs_run++;
                if (fs_run > fs_run_max) fs_run_max = fs_run;
            end else begin
                fs_run = 0;
            end
            if (!vs[1] && t >= 1 && t <= 550) vs_lo_n++;
            for (int i = 1; i < N; i++) begin
                if (dx[i] == 10'd16 && t_dx[i] < 0) t_dx[i] = t;
                if (prev_bn[i] && !bn[i] && t_bf[i] < 0) t_bf[i] = t;
                prev_bn[i] = bn[i];
            end
        end
    end

    int   exp_dx [7] = '{0, 0, 1, 1, 2, 2, 3};
    logic exp_vc [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int   exp_lag [N] = '{0, 0, 2, 4, 6};

    initial begin
        bit found;
        #1 Reset_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        #1;
        chk("rst_vclk", 64'(vclk[0]), 64'd1);
        chk("rst_hs", 64'(hs[0]), 64'd1);
        chk("rst_vs", 64'(vs[1]), 64'd1);
        chk("rst_bn", 64'(bn[0]), 64'd0);
        chk("rst_dx", 64'(dx[0]), 64'd0);
        chk("rst_fc", 64'(fc[1]), 64'd0);
        Reset_n = 1'b1;
        mon_en  = 1'b1;
        #1;
        chk("seq_dx 0", 64'(dx[0]), 64'(exp_dx[0]));
        chk("seq_vclk 0", 64'(vclk[0]), 64'(exp_vc[0]));
        for (int k = 1; k < 7; k++) begin
            @(negedge Clk);
            chk($sformatf("seq_dx %0d", k), 64'(dx[0]), 64'(exp_dx[k]));
            chk($sformatf("seq_vclk %0d", k), 64'(vclk[0]), 64'(exp_vc[k]));
        end

        while (t < 3300) @(negedge Clk);
        chk("hs_fall_t", 64'(hs_fall_t), 64'(1314));
        chk("hs_low_len", 64'(hs_rise_t - hs_fall_t), 64'(192));
        chk("blank_len", 64'(bn_fall_t - bn_rise_t), 64'(1280));
        chk("fs_count_ge2", 64'(fs_t.size() >= 2), 64'd1);
        if (fs_t.size() >= 2) begin
            chk("fs_first_t", 64'(fs_t[0]), 64'(550));
            chk("fs_period", 64'(fs_t[1] - fs_t[0]), 64'(550));
            chk("fc_after_1", 64'(fc_at[0]), 64'(1));
            chk("fc_after_2", 64'(fc_at[1]), 64'(2));
        end
        chk("fs_width", 64'(fs_run_max), 64'(1));
        chk("vs_low_len", 64'(vs_lo_n), 64'(100));
        for (int i = 1; i < N; i++)
            chk($sformatf("pd_lag i%0d", i), 64'(t_bf[i] - t_dx[i]),
                64'(exp_lag[i]));

        while (t < 3400) @(negedge Clk);
        #1;
        force u_s0.fc_q = 16'hFFFF;
        fc_off[1] = 65535 - ((t / 2) / 275);
        repeat (3) @(negedge Clk);
        #1;
        release u_s0.fc_q;
        #1;
        chk("forced_fc", 64'(fc[1]), 64'hFFFF);
        found = 1'b0;
        repeat (600) begin
            @(negedge Clk);
            if (!found && fs[1]) begin
                found = 1'b1;
                chk("wrap_fc", 64'(fc[1]), 64'h0);
            end
        end
        chk("wrap_fs_seen", 64'(found), 64'd1);

        found = 1'b0;
        repeat (1200) begin
            @(negedge Clk);
            if (!found && dx[1] == 10'd19 && dy[1] == 10'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_found", 64'(found), 64'd1);
        chk("mid_pre_hs", 64'(hs[1]), 64'd0);
        #1 Reset_n = 1'b0;
        for (int i = 0; i < N; i++) fc_off[i] = 0;
        #1;
        chk("mid_hs", 64'(hs[1]), 64'd1);
        chk("mid_bn", 64'(bn[1]), 64'd0);
        chk("mid_hs_def", 64'(hs[0]), 64'd1);
        chk("mid_dx", 64'(dx[1]), 64'd0);
        chk("mid_fc", 64'(fc[1]), 64'd0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        #1 Reset_n = 1'b1;
        #1;
        chk("rel_dx", 64'(dx[1]), 64'd0);
        chk("rel_dy", 64'(dy[1]), 64'd0);
        @(negedge Clk);
        chk("rel_dx1", 64'(dx[1]), 64'd0);
        chk("rel_fs", 64'(fs[1]), 64'd0);
        @(negedge Clk);
        chk("rel_dx2", 64'(dx[1]), 64'd1);
        chk("rel_fc", 64'(fc[1]), 64'd0);
        repeat (600) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
